// File: rtl/pc_pkg.sv
// pc_pkg: shared types, default parameters and the power-on offset table for the PC sequencer.
package pc_pkg;
    localparam int PC_W        = 12;
    localparam int SEL_W       = 4;
    localparam int STACK_DEPTH = 4;
    localparam int START_PC    = 0;

    typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;

    // Signed offsets; callers truncate to their own PC width
    function automatic int lut_default(input int idx);
        case (idx)
            0:       return -5;
            1:       return 20;
            2:       return -1;
            13:      return -130;
            14:      return 13;
            15:      return -120;
            default: return 0;
        endcase
    endfunction
endpackage

// File: rtl/pc_sequencer_lut.sv
// pc_offset_lut: 2**L x D offset register file, reset to the package defaults, one write and one comb read port.
module pc_offset_lut
    import pc_pkg::*;
#(
    parameter int D = PC_W,
    parameter int L = SEL_W
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         we,
    input  logic [L-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic [L-1:0] raddr,
    output logic [D-1:0] rdata
);
    logic [D-1:0] mem_q [2**L];
    logic [D-1:0] mem_d [2**L];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 2**L; i++) mem_q[i] <= D'(lut_default(i));
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with run/halt FSM, stall, relative branches and a bounded call/return stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int D      = PC_W,
    parameter int L      = SEL_W,
    parameter int SDEPTH = STACK_DEPTH,
    parameter int START  = START_PC
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         branch_taken,
    input  logic         call,
    input  logic         ret,
    input  logic         imm_or_lut,
    input  logic [L-1:0] pc_ctrl_input,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic [D-1:0] pc,
    output logic         running,
    output logic         done,
    output logic         stack_err
);
    localparam int CW = $clog2(SDEPTH + 1);
    localparam int AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(SDEPTH);

    pc_state_t    state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] stk_q [SDEPTH];
    logic [D-1:0] stk_d [SDEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic         err_q, err_d, running_q, running_d, done_q, done_d;
    logic [D-1:0] lut_off, offset, target, inc;
    logic [AW-1:0] top_idx, push_idx;

    pc_offset_lut #(.D(D), .L(L)) u_lut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .we     (lut_we),
        .waddr  (lut_waddr),
        .wdata  (lut_wdata),
        .raddr  (pc_ctrl_input),
        .rdata  (lut_off)
    );

    assign offset   = imm_or_lut ? lut_off : {{(D-L){pc_ctrl_input[L-1]}}, pc_ctrl_input};
    assign target   = pc_q + offset;
    assign inc      = pc_q + D'(1);
    assign top_idx  = AW'(cnt_q - CW'(1));
    assign push_idx = AW'(cnt_q);

    // Stall freezes everything except the LUT, including a start request
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        stk_d   = stk_q;
        err_d   = err_q;
        if (stall) begin
        end else if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                pc_d    = D'(START);
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        end else if (halt_req) begin
            state_d = HALT;
        end else if (ret) begin
            if (cnt_q == '0) begin
                err_d   = 1'b1;
                state_d = HALT;
            end else begin
                pc_d  = stk_q[top_idx];
                cnt_d = cnt_q - CW'(1);
            end
        end else if (branch_taken) begin
            if (call && cnt_q == FULL) begin
                err_d   = 1'b1;
                state_d = HALT;
            end else begin
                if (call) begin
                    stk_d[push_idx] = inc;
                    cnt_d           = cnt_q + CW'(1);
                end
                pc_d = target;
            end
        end else begin
            pc_d = inc;
        end
        running_d = state_d == RUN;
        done_d    = state_d == HALT;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            stk_q     <= stk_d;
            err_q     <= err_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign stack_err = err_q;
endmodule
